// File: rtl/axis_test_pkg.sv
// Shared types and sizing for the AXI-Stream result-capture test loop.
// State encoding, default widths and a saturating counter helper.
package axis_test_pkg;

   localparam int AXIS_DATA_W   = 32;
   localparam int CAPTURE_DEPTH = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CAPT = 2'd1,
      DONE = 2'd2
   } cap_state_e;

   // Cycle counters stick at all-ones rather than wrapping back to a small value.
   function automatic logic [31:0] sat_inc32(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/axis_result_capture_ram.sv
// Capture buffer: one write port, one read port with a registered read.
// Contents are not reset; only the read register clears so readback starts at 0.
module capture_ram #(
   parameter int WIDTH = 45,
   parameter int DEPTH = 16,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             wr_en_i,
   input  logic [AW-1:0]    wr_addr_i,
   input  logic [WIDTH-1:0] wr_data_i,
   input  logic [AW-1:0]    rd_addr_i,
   output logic [WIDTH-1:0] rd_data_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] rd_word_q;

   always_ff @(posedge clock) begin
      if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rd_word_q <= '0;
      end else begin
         rd_word_q <= mem_q[rd_addr_i];
      end
   end

   assign rd_data_o = rd_word_q;

endmodule

// File: rtl/axis_result_capture.sv
// AXI-Stream sink that captures one packet after an arm edge and measures
// the latency from the arm edge to the first accepted beat, for VIO readback.
module axis_result_capture
   import axis_test_pkg::*;
#(
   parameter int DATA_W       = AXIS_DATA_W,
   parameter int DEPTH        = CAPTURE_DEPTH,
   parameter bit BACKPRESSURE = 1'b0
) (
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic [DATA_W-1:0]        s_tdata,
   input  logic                     s_tvalid,
   output logic                     s_tready,
   input  logic                     s_tlast,
   input  logic [DATA_W/8-1:0]      s_tkeep,
   input  logic                     s_tuser,
   input  logic                     arm,
   input  logic [$clog2(DEPTH)-1:0] rd_addr,
   output logic [DATA_W-1:0]        rd_data,
   output logic [DATA_W/8:0]        rd_meta,
   output logic [$clog2(DEPTH):0]   beat_count,
   output logic [31:0]              first_cycles,
   output logic                     busy,
   output logic                     done,
   output logic                     overflow
);

   localparam int AW     = $clog2(DEPTH);
   localparam int KW     = DATA_W / 8;
   localparam int WORD_W = DATA_W + KW + 1;
   localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);
   localparam logic [AW:0] ONE_C   = (AW + 1)'(1);

   cap_state_e        state_q, state_d;
   logic              arm_q;
   logic              live_q;
   logic [AW:0]       count_q, count_d;
   logic [31:0]       first_q, first_d;
   logic              seen_q, seen_d;
   logic              ovf_q, ovf_d;

   logic              arm_edge;
   logic              accept;
   logic              buf_full;
   logic              wr_en;
   logic [WORD_W-1:0] wr_word;
   logic [WORD_W-1:0] rd_word;

   assign arm_edge = arm & ~arm_q;
   assign buf_full = (count_q == DEPTH_C);
   assign accept   = s_tvalid & s_tready;
   assign wr_word  = {s_tuser, s_tkeep, s_tdata};

   // live_q keeps ready low while in reset; it rises on the first edge after release.
   generate
      if (BACKPRESSURE) begin : g_bp
         assign s_tready = live_q && (state_q == CAPT) && !buf_full;
      end else begin : g_nobp
         assign s_tready = live_q;
      end
   endgenerate

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         arm_q   <= 1'b0;
         live_q  <= 1'b0;
         count_q <= '0;
         first_q <= '0;
         seen_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         arm_q   <= arm;
         live_q  <= 1'b1;
         count_q <= count_d;
         first_q <= first_d;
         seen_q  <= seen_d;
         ovf_q   <= ovf_d;
      end
   end

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      first_d = first_q;
      seen_d  = seen_q;
      ovf_d   = ovf_q;
      wr_en   = 1'b0;

      // An arm edge restarts from any state; a beat in that same cycle is ignored.
      if (arm_edge) begin
         state_d = CAPT;
         count_d = '0;
         first_d = '0;
         seen_d  = 1'b0;
         ovf_d   = 1'b0;
      end else if (state_q == CAPT) begin
         if (!seen_q) begin
            first_d = sat_inc32(first_q);
         end
         if (accept) begin
            seen_d = 1'b1;
            if (!buf_full) begin
               wr_en   = 1'b1;
               count_d = count_q + ONE_C;
            end else begin
               ovf_d = 1'b1;
            end
            if (s_tlast) begin
               state_d = DONE;
            end
         end
      end
   end

   capture_ram #(
      .WIDTH (WORD_W),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ram (
      .clock     (clock),
      .reset_n   (reset_n),
      .wr_en_i   (wr_en),
      .wr_addr_i (count_q[AW-1:0]),
      .wr_data_i (wr_word),
      .rd_addr_i (rd_addr),
      .rd_data_o (rd_word)
   );

   assign rd_data      = rd_word[DATA_W-1:0];
   assign rd_meta      = rd_word[WORD_W-1:DATA_W];
   assign beat_count   = count_q;
   assign first_cycles = first_q;
   assign busy         = (state_q == CAPT);
   assign done         = (state_q == DONE);
   assign overflow     = ovf_q;

endmodule

// File: tb/tb_axis_result_capture.sv
// Directed-sequence bench with random payloads for axis_result_capture,
// one instance without and one with backpressure sharing the same stimulus.
module tb_axis_result_capture;

   localparam int DW = 32;
   localparam int DP = 16;

   logic          clock = 1'b0;
   logic          reset_n = 1'b0;
   logic [DW-1:0] s_tdata = '0;
   logic          s_tvalid = 1'b0;
   logic          s_tlast = 1'b0;
   logic [3:0]    s_tkeep = '0;
   logic          s_tuser = 1'b0;
   logic          arm = 1'b0;
   logic [3:0]    rd_addr = '0;

   logic          r0_tready, r1_tready;
   logic [DW-1:0] r0_rd_data, r1_rd_data;
   logic [4:0]    r0_rd_meta, r1_rd_meta;
   logic [4:0]    r0_count, r1_count;
   logic [31:0]   r0_first, r1_first;
   logic          r0_busy, r1_busy, r0_done, r1_done, r0_ovf, r1_ovf;

   int pass_cnt = 0;
   int check_cnt = 0;

   // Reference packet: what was offered; expected capture = first min(n, DP) beats.
   logic [31:0] pk_data [0:31];
   logic [3:0]  pk_keep [0:31];
   logic        pk_user [0:31];

   always #5 clock = ~clock;

   axis_result_capture #(.DATA_W(DW), .DEPTH(DP), .BACKPRESSURE(1'b0)) dut0 (
      .clock(clock), .reset_n(reset_n), .s_tdata(s_tdata), .s_tvalid(s_tvalid),
      .s_tready(r0_tready), .s_tlast(s_tlast), .s_tkeep(s_tkeep), .s_tuser(s_tuser),
      .arm(arm), .rd_addr(rd_addr), .rd_data(r0_rd_data), .rd_meta(r0_rd_meta),
      .beat_count(r0_count), .first_cycles(r0_first), .busy(r0_busy),
      .done(r0_done), .overflow(r0_ovf)
   );

   axis_result_capture #(.DATA_W(DW), .DEPTH(DP), .BACKPRESSURE(1'b1)) dut1 (
      .clock(clock), .reset_n(reset_n), .s_tdata(s_tdata), .s_tvalid(s_tvalid),
      .s_tready(r1_tready), .s_tlast(s_tlast), .s_tkeep(s_tkeep), .s_tuser(s_tuser),
      .arm(arm), .rd_addr(rd_addr), .rd_data(r1_rd_data), .rd_meta(r1_rd_meta),
      .beat_count(r1_count), .first_cycles(r1_first), .busy(r1_busy),
      .done(r1_done), .overflow(r1_ovf)
   );

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      check_cnt = check_cnt + 1;
      assert (obs === exp) pass_cnt = pass_cnt + 1;
      else begin
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic gen_packet(input int n);
      for (int i = 0; i < n; i++) begin
         pk_data[i] = $urandom;
         pk_keep[i] = 4'($urandom_range(0, 15));
         pk_user[i] = 1'($urandom_range(0, 1));
      end
   endtask

   task automatic send_range(input int lo, input int hi, input int last_idx);
      for (int i = lo; i < hi; i++) begin
         s_tvalid = 1'b1;
         s_tdata  = pk_data[i];
         s_tkeep  = pk_keep[i];
         s_tuser  = pk_user[i];
         s_tlast  = (i == last_idx);
         step();
      end
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
      $display("pkt beats %0d..%0d sent, tlast index %0d", lo, hi - 1, last_idx);
   endtask

   task automatic arm_pulse();
      arm = 1'b1;
      step();
      arm = 1'b0;
   endtask

   task automatic readback(input bit sel, input int lo, input int n);
      for (int i = 0; i < n; i++) begin
         rd_addr = 4'(i);
         step();
         if (sel) begin
            check($sformatf("bp1_rd_data[%0d]", i), 64'(r1_rd_data), 64'(pk_data[lo + i]));
            check($sformatf("bp1_rd_meta[%0d]", i), 64'(r1_rd_meta), 64'({pk_user[lo + i], pk_keep[lo + i]}));
         end else begin
            check($sformatf("rd_data[%0d]", i), 64'(r0_rd_data), 64'(pk_data[lo + i]));
            check($sformatf("rd_meta[%0d]", i), 64'(r0_rd_meta), 64'({pk_user[lo + i], pk_keep[lo + i]}));
         end
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_tready0"}, 64'(r0_tready), 64'd0);
      check({tag, "_tready1"}, 64'(r1_tready), 64'd0);
      check({tag, "_rd_data"}, 64'(r0_rd_data), 64'd0);
      check({tag, "_rd_meta"}, 64'(r0_rd_meta), 64'd0);
      check({tag, "_count"}, 64'(r0_count), 64'd0);
      check({tag, "_first"}, 64'(r0_first), 64'd0);
      check({tag, "_flags"}, 64'({r0_busy, r0_done, r0_ovf, r1_busy, r1_done, r1_ovf}), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc;
      int full_at;
      int idx;
      logic rdy;

      // Reset state
      repeat (3) step();
      check_all_zero("reset");
      reset_n = 1'b1;
      step();
      check("ready_after_reset_bp0", 64'(r0_tready), 64'd1);
      check("ready_idle_bp1", 64'(r1_tready), 64'd0);

      // 1: three back-to-back beats right after the arm edge
      gen_packet(3);
      pk_data[0] = 32'h11; pk_data[1] = 32'h22; pk_data[2] = 32'h33;
      arm_pulse();
      check("t1_busy", 64'(r0_busy), 64'd1);
      send_range(0, 3, 2);
      check("t1_count", 64'(r0_count), 64'd3);
      check("t1_done", 64'({r0_done, r0_busy, r0_ovf}), 64'b100);
      check("t1_first", 64'(r0_first), 64'd1);
      readback(1'b0, 0, 3);

      // 2: ten idle cycles before a single-beat packet
      gen_packet(1);
      arm_pulse();
      check("t2_cleared_done", 64'(r0_done), 64'd0);
      repeat (10) step();
      send_range(0, 1, 0);
      check("t2_first", 64'(r0_first), 64'd11);
      check("t2_count", 64'(r0_count), 64'd1);
      check("t2_done", 64'(r0_done), 64'd1);
      readback(1'b0, 0, 1);

      // 3: 20-beat packet into a 16-deep buffer without backpressure
      gen_packet(20);
      arm_pulse();
      send_range(0, 20, 19);
      check("t3_count", 64'(r0_count), 64'd16);
      check("t3_ovf", 64'(r0_ovf), 64'd1);
      check("t3_done", 64'(r0_done), 64'd1);
      check("t3_first", 64'(r0_first), 64'd1);
      readback(1'b0, 0, DP);

      // 4: backpressure instance offered 20 beats
      gen_packet(20);
      arm_pulse();
      acc = 0;
      full_at = -1;
      for (int c = 0; c < 24; c++) begin
         idx = (acc > 19) ? 19 : acc;
         s_tvalid = 1'b1;
         s_tdata  = pk_data[idx];
         s_tkeep  = pk_keep[idx];
         s_tuser  = pk_user[idx];
         s_tlast  = (idx == 19);
         rdy = r1_tready;
         step();
         if (rdy) begin
            acc = acc + 1;
            if (acc == DP) full_at = c + 1;
         end
      end
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
      $display("bp1 offered 24 cycles, %0d beats accepted", acc);
      check("t4_accepted", 64'(acc), 64'd16);
      check("t4_full_at", 64'(full_at), 64'd16);
      check("t4_ready_low", 64'(r1_tready), 64'd0);
      check("t4_ovf", 64'(r1_ovf), 64'd0);
      check("t4_done", 64'(r1_done), 64'd0);
      check("t4_busy", 64'(r1_busy), 64'd1);
      check("t4_count", 64'(r1_count), 64'd16);
      check("t4_first", 64'(r1_first), 64'd1);
      readback(1'b1, 0, DP);

      // 5: beats while idle are not stored; a held arm starts only one capture
      reset_n = 1'b0;
      #1;
      check_all_zero("midreset");
      step();
      reset_n = 1'b1;
      step();
      gen_packet(3);
      send_range(0, 3, 2);
      check("t5_idle_count", 64'(r0_count), 64'd0);
      check("t5_idle_flags", 64'({r0_busy, r0_done, r0_ovf}), 64'd0);
      arm = 1'b1;
      step();
      repeat (4) step();
      gen_packet(2);
      send_range(0, 2, 1);
      arm = 1'b0;
      check("t5_first", 64'(r0_first), 64'd5);
      check("t5_count", 64'(r0_count), 64'd2);
      check("t5_done", 64'(r0_done), 64'd1);
      readback(1'b0, 0, 2);

      // Arm edge during capture restarts; the beat in the edge cycle is dropped
      gen_packet(5);
      arm_pulse();
      send_range(0, 2, -1);
      arm      = 1'b1;
      s_tvalid = 1'b1;
      s_tdata  = pk_data[2];
      s_tkeep  = pk_keep[2];
      s_tuser  = pk_user[2];
      step();
      arm = 1'b0;
      send_range(3, 5, 4);
      check("restart_count", 64'(r0_count), 64'd2);
      check("restart_first", 64'(r0_first), 64'd1);
      check("restart_done", 64'(r0_done), 64'd1);
      readback(1'b0, 3, 2);

      // 6: reset mid-capture, then a fresh capture lands at index 0
      gen_packet(4);
      arm_pulse();
      send_range(0, 2, -1);
      check("t6_partial_count", 64'(r0_count), 64'd2);
      reset_n = 1'b0;
      #1;
      check_all_zero("t6_reset");
      step();
      reset_n = 1'b1;
      step();
      gen_packet(4);
      arm_pulse();
      send_range(0, 4, 3);
      check("t6_count", 64'(r0_count), 64'd4);
      check("t6_done", 64'(r0_done), 64'd1);
      check("t6_first", 64'(r0_first), 64'd1);
      readback(1'b0, 0, 4);

      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
